// File: rtl/tracer_adapter_pkg.sv
// ============================================================================
// Module      : tracer_adapter_pkg
// Description : Shared definitions for the tracer adapter register bank:
//               register offsets, CFG/INTCFG/STATUS bit positions and the
//               bus / channel state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tracer_adapter_pkg;

    // Register offsets within a channel's 32-byte window
    localparam logic [4:0] c_OFF_SADDR   = 5'h00;
    localparam logic [4:0] c_OFF_SIZE    = 5'h04;
    localparam logic [4:0] c_OFF_CFG     = 5'h08;
    localparam logic [4:0] c_OFF_INTCFG  = 5'h0C;
    localparam logic [4:0] c_OFF_STATUS  = 5'h10;
    localparam logic [4:0] c_OFF_XFERCNT = 5'h14;

    // CFG write-side bit positions
    localparam int c_CFG_CONT      = 0;
    localparam int c_CFG_DSIZE_LSB = 1;
    localparam int c_CFG_FILTER    = 3;
    localparam int c_CFG_EN        = 4;
    localparam int c_CFG_CLR       = 5;

    // INTCFG bit positions
    localparam int c_INT_DONE_IE = 0;
    localparam int c_INT_OVF_IE  = 1;

    // STATUS bit positions
    localparam int c_ST_DONE = 0;
    localparam int c_ST_OVF  = 1;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1
    } ch_state_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/tracer_adapter_ch_regs.sv
// ============================================================================
// Module      : tracer_adapter_ch_regs
// Description : Per-channel register state: SADDR/SIZE/CFG config, INTCFG,
//               sticky STATUS, saturating XFERCNT, done-edge detection,
//               channel FSM and registered interrupt.
// Ports       : clk_i/rst_i          clock, async active-high reset
//               wr_en_i, reg_off_i,  committed write strobe, offset, data
//               wdata_i
//               rx_en_i/rx_pending_i uDMA channel status
//               startaddr_o..clr_o   channel configuration and pulses
//               intcfg_o/status_o/   readback fields for the top read mux
//               xfercnt_o
//               irq_o                registered interrupt
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tracer_adapter_ch_regs
    import tracer_adapter_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int CNT_W          = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic [4:0]                reg_off_i,
    input  logic [31:0]               wdata_i,
    input  logic                      rx_en_i,
    input  logic                      rx_pending_i,
    output logic [L2_AWIDTH_NOAL-1:0] startaddr_o,
    output logic [TRANS_SIZE-1:0]     size_o,
    output logic [1:0]                datasize_o,
    output logic                      continuous_o,
    output logic                      filter_o,
    output logic                      en_o,
    output logic                      clr_o,
    output logic [1:0]                intcfg_o,
    output logic [3:0]                status_o,
    output logic [CNT_W-1:0]          xfercnt_o,
    output logic                      irq_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [L2_AWIDTH_NOAL-1:0] saddr_q, saddr_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic [1:0]                dsize_q, dsize_d;
    logic                      cont_q, cont_d;
    logic                      filter_q, filter_d;
    logic                      en_q, en_d;
    logic                      clr_q, clr_d;
    logic                      done_ie_q, done_ie_d;
    logic                      ovf_ie_q, ovf_ie_d;
    logic                      st_done_q, st_done_d;
    logic                      st_ovf_q, st_ovf_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rx_en_prev_q;
    logic                      irq_q, irq_d;
    ch_state_e                 state_q, state_d;

    logic w_done;
    logic w_unused_wdata;

    // Only some wdata bits land in registers for a given parameter set
    assign w_unused_wdata = ^wdata_i;

    // Transfer completes when the channel enable drops with nothing pending
    assign w_done = rx_en_prev_q & ~rx_en_i & ~rx_pending_i;

    always_comb begin
        saddr_d   = saddr_q;
        size_d    = size_q;
        dsize_d   = dsize_q;
        cont_d    = cont_q;
        filter_d  = filter_q;
        en_d      = 1'b0;
        clr_d     = 1'b0;
        done_ie_d = done_ie_q;
        ovf_ie_d  = ovf_ie_q;
        cnt_d     = cnt_q;
        state_d   = state_q;

        if (wr_en_i) begin
            case (reg_off_i)
                c_OFF_SADDR: saddr_d = wdata_i[L2_AWIDTH_NOAL-1:0];
                c_OFF_SIZE:  size_d  = wdata_i[TRANS_SIZE-1:0];
                c_OFF_CFG: begin
                    cont_d   = wdata_i[c_CFG_CONT];
                    dsize_d  = wdata_i[c_CFG_DSIZE_LSB +: 2];
                    filter_d = wdata_i[c_CFG_FILTER];
                    en_d     = wdata_i[c_CFG_EN];
                    clr_d    = wdata_i[c_CFG_CLR];
                end
                c_OFF_INTCFG: begin
                    done_ie_d = wdata_i[c_INT_DONE_IE];
                    ovf_ie_d  = wdata_i[c_INT_OVF_IE];
                end
                default: ;
            endcase
        end

        // W1C loses against a same-cycle set
        st_done_d = (st_done_q & ~(wr_en_i && reg_off_i == c_OFF_STATUS && wdata_i[c_ST_DONE]))
                  | w_done;
        st_ovf_d  = (st_ovf_q & ~(wr_en_i && reg_off_i == c_OFF_STATUS && wdata_i[c_ST_OVF]))
                  | (w_done & st_done_q);

        // Any write clears the counter; a coincident done counts as the first
        if (wr_en_i && reg_off_i == c_OFF_XFERCNT) begin
            cnt_d = w_done ? CNT_W'(1) : '0;
        end else if (w_done && cnt_q != c_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        irq_d = (st_done_q & done_ie_q) | (st_ovf_q & ovf_ie_q);

        case (state_q)
            CH_IDLE: if (en_q) state_d = CH_RUN;
            CH_RUN:  if (w_done && !cont_q) state_d = CH_IDLE;
            default: state_d = CH_IDLE;
        endcase
        if (clr_q) state_d = CH_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            saddr_q      <= '0;
            size_q       <= '0;
            dsize_q      <= '0;
            cont_q       <= 1'b0;
            filter_q     <= 1'b0;
            en_q         <= 1'b0;
            clr_q        <= 1'b0;
            done_ie_q    <= 1'b0;
            ovf_ie_q     <= 1'b0;
            st_done_q    <= 1'b0;
            st_ovf_q     <= 1'b0;
            cnt_q        <= '0;
            rx_en_prev_q <= 1'b0;
            irq_q        <= 1'b0;
            state_q      <= CH_IDLE;
        end else begin
            saddr_q      <= saddr_d;
            size_q       <= size_d;
            dsize_q      <= dsize_d;
            cont_q       <= cont_d;
            filter_q     <= filter_d;
            en_q         <= en_d;
            clr_q        <= clr_d;
            done_ie_q    <= done_ie_d;
            ovf_ie_q     <= ovf_ie_d;
            st_done_q    <= st_done_d;
            st_ovf_q     <= st_ovf_d;
            cnt_q        <= cnt_d;
            rx_en_prev_q <= rx_en_i;
            irq_q        <= irq_d;
            state_q      <= state_d;
        end
    end

    assign startaddr_o  = saddr_q;
    assign size_o       = size_q;
    assign datasize_o   = dsize_q;
    assign continuous_o = cont_q;
    assign filter_o     = filter_q;
    assign en_o         = en_q;
    assign clr_o        = clr_q;
    assign intcfg_o     = {ovf_ie_q, done_ie_q};
    assign status_o     = {state_q, st_ovf_q, st_done_q};
    assign xfercnt_o    = cnt_q;
    assign irq_o        = irq_q;

endmodule

`default_nettype wire

// File: rtl/tracer_adapter_reg_bank.sv
// ============================================================================
// Module      : tracer_adapter_reg_bank
// Description : Configuration register bank for NUM_CH uDMA RX tracer
//               channels. Two-cycle request/acknowledge bus, per-channel
//               register windows of 32 bytes selected by the upper address bits.
// Ports       : clk_i/rst_i            clock, async active-high reset
//               cfg_*_i / cfg_*_o      config bus (valid/rw_n/addr/data, ready)
//               cfg_rx_*_o             per-channel configuration and pulses
//               cfg_rx_*_i             per-channel uDMA status
//               irq_o / irq_any_o      per-channel and combined interrupts
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tracer_adapter_reg_bank
    import tracer_adapter_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int CNT_W          = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [31:0]                        cfg_data_i,
    input  logic [5+$clog2(NUM_CH)-1:0]        cfg_addr_i,
    input  logic                               cfg_valid_i,
    input  logic                               cfg_rw_ni,
    output logic [31:0]                        cfg_data_o,
    output logic                               cfg_ready_o,
    output logic [NUM_CH*L2_AWIDTH_NOAL-1:0]   cfg_rx_startaddr_o,
    output logic [NUM_CH*TRANS_SIZE-1:0]       cfg_rx_size_o,
    output logic [NUM_CH*2-1:0]                cfg_rx_datasize_o,
    output logic [NUM_CH-1:0]                  cfg_rx_continuous_o,
    output logic [NUM_CH-1:0]                  cfg_rx_filter_o,
    output logic [NUM_CH-1:0]                  cfg_rx_en_o,
    output logic [NUM_CH-1:0]                  cfg_rx_clr_o,
    input  logic [NUM_CH-1:0]                  cfg_rx_en_i,
    input  logic [NUM_CH-1:0]                  cfg_rx_pending_i,
    input  logic [NUM_CH*L2_AWIDTH_NOAL-1:0]   cfg_rx_curr_addr_i,
    input  logic [NUM_CH*TRANS_SIZE-1:0]       cfg_rx_bytes_left_i,
    output logic [NUM_CH-1:0]                  irq_o,
    output logic                               irq_any_o
);

    localparam int ADDR_W = 5 + $clog2(NUM_CH);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    bus_state_e        bus_state_q, bus_state_d;
    logic [31:0]       data_q, data_d;
    logic              w_wr_commit;
    logic [CH_W-1:0]   w_ch_idx;
    logic [NUM_CH-1:0] w_wr_en;
    logic [31:0]       w_rd_data;
    logic [1:0]        w_intcfg  [NUM_CH];
    logic [3:0]        w_status  [NUM_CH];
    logic [CNT_W-1:0]  w_xfercnt [NUM_CH];

    generate
        if (NUM_CH > 1) begin : g_ch_idx
            assign w_ch_idx = cfg_addr_i[ADDR_W-1:5];
        end else begin : g_ch_idx_single
            assign w_ch_idx = '0;
        end
    endgenerate

    // Writes commit once, on the IDLE->ACK edge
    assign w_wr_commit = (bus_state_q == BUS_IDLE) && cfg_valid_i && !cfg_rw_ni;

    // Channel indices beyond NUM_CH match no entry: reads give 0, writes vanish
    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(w_ch_idx) == c) begin
                case (cfg_addr_i[4:0])
                    c_OFF_SADDR:   w_rd_data = 32'(cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
                    c_OFF_SIZE:    w_rd_data = 32'(cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]);
                    c_OFF_CFG:     w_rd_data = {26'h0, cfg_rx_pending_i[c], cfg_rx_en_i[c],
                                                cfg_rx_filter_o[c], cfg_rx_datasize_o[c*2 +: 2],
                                                cfg_rx_continuous_o[c]};
                    c_OFF_INTCFG:  w_rd_data = 32'(w_intcfg[c]);
                    c_OFF_STATUS:  w_rd_data = 32'(w_status[c]);
                    c_OFF_XFERCNT: w_rd_data = 32'(w_xfercnt[c]);
                    default:       w_rd_data = '0;
                endcase
            end
        end
    end

    // Read data is captured on entry to ACK and returns to 0 when ACK ends
    always_comb begin
        bus_state_d = bus_state_q;
        data_d      = '0;
        case (bus_state_q)
            BUS_IDLE: begin
                if (cfg_valid_i) begin
                    bus_state_d = BUS_ACK;
                    if (cfg_rw_ni) data_d = w_rd_data;
                end
            end
            BUS_ACK:  bus_state_d = BUS_IDLE;
            default:  bus_state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_state_q <= BUS_IDLE;
            data_q      <= '0;
        end else begin
            bus_state_q <= bus_state_d;
            data_q      <= data_d;
        end
    end

    assign cfg_ready_o = (bus_state_q == BUS_ACK);
    assign cfg_data_o  = data_q;
    assign irq_any_o   = |irq_o;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_wr_en[c] = w_wr_commit && (w_ch_idx == CH_W'(c));

            tracer_adapter_ch_regs #(
                .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
                .TRANS_SIZE     (TRANS_SIZE),
                .CNT_W          (CNT_W)
            ) u_ch_regs (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .wr_en_i      (w_wr_en[c]),
                .reg_off_i    (cfg_addr_i[4:0]),
                .wdata_i      (cfg_data_i),
                .rx_en_i      (cfg_rx_en_i[c]),
                .rx_pending_i (cfg_rx_pending_i[c]),
                .startaddr_o  (cfg_rx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
                .size_o       (cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
                .datasize_o   (cfg_rx_datasize_o[c*2 +: 2]),
                .continuous_o (cfg_rx_continuous_o[c]),
                .filter_o     (cfg_rx_filter_o[c]),
                .en_o         (cfg_rx_en_o[c]),
                .clr_o        (cfg_rx_clr_o[c]),
                .intcfg_o     (w_intcfg[c]),
                .status_o     (w_status[c]),
                .xfercnt_o    (w_xfercnt[c]),
                .irq_o        (irq_o[c])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_tracer_adapter_reg_bank.sv
// ============================================================================
// Module      : tb_tracer_adapter_reg_bank
// Description : Directed self-checking bench for tracer_adapter_reg_bank.
//               A second instance with three channels gives the address
//               space a channel index (3) that lies beyond NUM_CH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tracer_adapter_reg_bank;

    localparam int NUM_CH = 2;
    localparam int L2     = 12;
    localparam int TS     = 16;
    localparam int CNT_W  = 8;
    localparam int AW     = 6;

    localparam logic [4:0] O_SADDR = 5'h00, O_SIZE = 5'h04, O_CFG = 5'h08;
    localparam logic [4:0] O_INTCFG = 5'h0C, O_STATUS = 5'h10, O_XFERCNT = 5'h14;

    logic               clk, rst;
    logic [31:0]        cfg_data_i, cfg_data_o;
    logic [AW-1:0]      cfg_addr_i;
    logic               cfg_valid_i, cfg_rw_ni, cfg_ready_o;
    logic [NUM_CH*L2-1:0] startaddr, curr_addr;
    logic [NUM_CH*TS-1:0] size_o, bytes_left;
    logic [NUM_CH*2-1:0]  datasize;
    logic [NUM_CH-1:0]  cont, filter, en_o, clr_o, rx_en, rx_pend, irq;
    logic               irq_any;

    // three-channel instance
    logic [31:0]        d2_wdata, d2_rdata;
    logic [6:0]         d2_addr;
    logic               d2_valid, d2_rw_n, d2_ready;
    logic [3*L2-1:0]    d2_startaddr;
    logic [3*TS-1:0]    d2_size;
    logic [5:0]         d2_datasize;
    logic [2:0]         d2_cont, d2_filter, d2_en_o, d2_clr_o, d2_irq;
    logic               d2_irq_any;

    int checks = 0;
    int errors = 0;

    tracer_adapter_reg_bank #(
        .NUM_CH(NUM_CH), .L2_AWIDTH_NOAL(L2), .TRANS_SIZE(TS), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
        .cfg_rw_ni(cfg_rw_ni), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .cfg_rx_startaddr_o(startaddr), .cfg_rx_size_o(size_o),
        .cfg_rx_datasize_o(datasize), .cfg_rx_continuous_o(cont),
        .cfg_rx_filter_o(filter), .cfg_rx_en_o(en_o), .cfg_rx_clr_o(clr_o),
        .cfg_rx_en_i(rx_en), .cfg_rx_pending_i(rx_pend),
        .cfg_rx_curr_addr_i(curr_addr), .cfg_rx_bytes_left_i(bytes_left),
        .irq_o(irq), .irq_any_o(irq_any)
    );

    tracer_adapter_reg_bank #(
        .NUM_CH(3), .L2_AWIDTH_NOAL(L2), .TRANS_SIZE(TS), .CNT_W(CNT_W)
    ) dut3 (
        .clk_i(clk), .rst_i(rst),
        .cfg_data_i(d2_wdata), .cfg_addr_i(d2_addr), .cfg_valid_i(d2_valid),
        .cfg_rw_ni(d2_rw_n), .cfg_data_o(d2_rdata), .cfg_ready_o(d2_ready),
        .cfg_rx_startaddr_o(d2_startaddr), .cfg_rx_size_o(d2_size),
        .cfg_rx_datasize_o(d2_datasize), .cfg_rx_continuous_o(d2_cont),
        .cfg_rx_filter_o(d2_filter), .cfg_rx_en_o(d2_en_o), .cfg_rx_clr_o(d2_clr_o),
        .cfg_rx_en_i(3'b000), .cfg_rx_pending_i(3'b000),
        .cfg_rx_curr_addr_i({3*L2{1'b1}}), .cfg_rx_bytes_left_i({3*TS{1'b1}}),
        .irq_o(d2_irq), .irq_any_o(d2_irq_any)
    );

    always #5 clk = ~clk;

    // One full 2-cycle access; samples taken 1 time unit after each edge
    task automatic bus_xfer(input int ch, input logic [4:0] off, input logic rw_n,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic [31:0] rd_post, output logic rdy_pre,
                            output logic rdy_mid, output logic rdy_post,
                            output logic [NUM_CH-1:0] en_mid,
                            output logic [NUM_CH-1:0] en_post,
                            output logic [NUM_CH-1:0] clr_mid);
        @(negedge clk);
        cfg_addr_i  = AW'((ch << 5) | int'(off));
        cfg_valid_i = 1'b1;
        cfg_rw_ni   = rw_n;
        cfg_data_i  = wd;
        #1 rdy_pre = cfg_ready_o;
        @(posedge clk); #1;
        rd = cfg_data_o; rdy_mid = cfg_ready_o; en_mid = en_o; clr_mid = clr_o;
        @(negedge clk);
        cfg_valid_i = 1'b0; cfg_rw_ni = 1'b1; cfg_data_i = '0;
        @(posedge clk); #1;
        rdy_post = cfg_ready_o; en_post = en_o; rd_post = cfg_data_o;
    endtask

    task automatic wr(input int ch, input logic [4:0] off, input logic [31:0] d);
        logic [31:0] r, rp; logic a, b, c; logic [NUM_CH-1:0] x, y, z;
        bus_xfer(ch, off, 1'b0, d, r, rp, a, b, c, x, y, z);
    endtask

    task automatic rd(input int ch, input logic [4:0] off, output logic [31:0] d);
        logic [31:0] rp; logic a, b, c; logic [NUM_CH-1:0] x, y, z;
        bus_xfer(ch, off, 1'b1, 32'h0, d, rp, a, b, c, x, y, z);
    endtask

    task automatic bus3(input logic [6:0] a, input logic rw_n, input logic [31:0] wd,
                        output logic [31:0] r, output logic rdy,
                        output logic [2:0] en_m, output logic [2:0] clr_m);
        @(negedge clk);
        d2_addr = a; d2_valid = 1'b1; d2_rw_n = rw_n; d2_wdata = wd;
        @(posedge clk); #1;
        r = d2_rdata; rdy = d2_ready; en_m = d2_en_o; clr_m = d2_clr_o;
        @(negedge clk);
        d2_valid = 1'b0; d2_rw_n = 1'b1; d2_wdata = '0;
        @(posedge clk); #1;
    endtask

    // Enable high for one cycle then low with pending=0 -> one done event
    task automatic done_pulse(input int ch);
        @(negedge clk) rx_en[ch] = 1'b1;
        @(negedge clk) rx_en[ch] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cfg_ready_o); end
        checks++; if (cfg_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", cfg_data_o); end
        checks++; if ({en_o, clr_o, irq, irq_any, cont, filter} !== '0) begin errors++;
            $display("FAIL reset_outputs en=%b clr=%b irq=%b any=%b exp all 0", en_o, clr_o, irq, irq_any); end
        checks++; if ({startaddr, size_o, datasize} !== '0) begin errors++; $display("FAIL reset_cfg_regs got nonzero"); end
        rd(0, O_STATUS, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", v); end
        rd(1, O_XFERCNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_xfercnt got=%h exp=0", v); end
    endtask

    task automatic test_cfg_write();
        logic [31:0] r, rp, v; logic p0, p1, p2; logic [NUM_CH-1:0] em, ep, cm;
        bus_xfer(1, O_CFG, 1'b0, 32'h11, r, rp, p0, p1, p2, em, ep, cm);
        checks++; if ({p0, p1, p2} !== 3'b010) begin errors++; $display("FAIL cfg_ready_seq got=%b exp=010", {p0, p1, p2}); end
        checks++; if (em !== 2'b10) begin errors++; $display("FAIL cfg_en_pulse got=%b exp=10", em); end
        checks++; if (ep !== 2'b00) begin errors++; $display("FAIL cfg_en_pulse_end got=%b exp=00", ep); end
        checks++; if (cont !== 2'b10) begin errors++; $display("FAIL cfg_continuous got=%b exp=10", cont); end
        rd(1, O_STATUS, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL cfg_state_run got=%h exp=4", v); end
        wr(1, O_CFG, 32'h0E);
        checks++; if (datasize[3:2] !== 2'b11 || filter !== 2'b10 || cont !== 2'b00) begin errors++;
            $display("FAIL cfg_fields dsize=%b filter=%b cont=%b exp 11/10/00", datasize[3:2], filter, cont); end
        rd(1, O_CFG, v);
        checks++; if (v !== 32'h0E) begin errors++; $display("FAIL cfg_readback got=%h exp=e", v); end
    endtask

    task automatic test_data_regs();
        logic [31:0] v, rp; logic p0, p1, p2; logic [NUM_CH-1:0] em, ep, cm;
        wr(0, O_SADDR, 32'hFFFF_FABC);
        wr(1, O_SIZE, 32'hAAAA_1234);
        checks++; if (startaddr[11:0] !== 12'hABC || size_o[31:16] !== 16'h1234) begin errors++;
            $display("FAIL data_outputs saddr0=%h size1=%h exp abc/1234", startaddr[11:0], size_o[31:16]); end
        curr_addr  = {12'h5A5, 12'h000};
        bytes_left = {16'h0000, 16'hBEEF};
        bus_xfer(1, O_SADDR, 1'b1, 32'h0, v, rp, p0, p1, p2, em, ep, cm);
        checks++; if (v !== 32'h5A5) begin errors++; $display("FAIL saddr_read got=%h exp=5a5", v); end
        checks++; if (rp !== 32'h0) begin errors++; $display("FAIL data_after_ack got=%h exp=0", rp); end
        rd(0, O_SIZE, v);
        checks++; if (v !== 32'hBEEF) begin errors++; $display("FAIL size_read got=%h exp=beef", v); end
    endtask

    task automatic test_done_irq();
        logic [31:0] v;
        wr(0, O_INTCFG, 32'h1);
        done_pulse(0);
        checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_latency got=%b exp=0", irq[0]); end
        @(negedge clk);
        checks++; if (irq[0] !== 1'b1 || irq_any !== 1'b1) begin errors++;
            $display("FAIL irq_set irq=%b any=%b exp 1/1", irq[0], irq_any); end
        rd(0, O_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL done_status got=%h exp=1", v); end
        rd(0, O_XFERCNT, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL done_xfercnt got=%h exp=1", v); end
        wr(0, O_STATUS, 32'h1);
        checks++; if (irq[0] !== 1'b0 || irq_any !== 1'b0) begin errors++;
            $display("FAIL irq_clear irq=%b any=%b exp 0/0", irq[0], irq_any); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(0, O_XFERCNT, 32'h0);
        done_pulse(0);
        done_pulse(0);
        rd(0, O_STATUS, v);
        checks++; if (v !== 32'h3) begin errors++; $display("FAIL ovf_status got=%h exp=3", v); end
        rd(0, O_XFERCNT, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL ovf_xfercnt got=%h exp=2", v); end
        wr(0, O_INTCFG, 32'h2);
        checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL ovf_irq got=%b exp=1", irq[0]); end
        wr(0, O_STATUS, 32'h3);
        checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL ovf_irq_clear got=%b exp=0", irq[0]); end
        rd(0, O_STATUS, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovf_w1c got=%h exp=0", v); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] v;
        // done coincides with W1C of STATUS[0]
        @(negedge clk) rx_en[0] = 1'b1;
        @(negedge clk);
        rx_en[0] = 1'b0;
        cfg_addr_i = AW'(O_STATUS); cfg_valid_i = 1'b1; cfg_rw_ni = 1'b0; cfg_data_i = 32'h1;
        @(negedge clk);
        cfg_valid_i = 1'b0; cfg_rw_ni = 1'b1; cfg_data_i = '0;
        @(negedge clk);
        rd(0, O_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL same_cycle_status got=%h exp=1", v); end
        // done coincides with an XFERCNT clear
        @(negedge clk) rx_en[0] = 1'b1;
        @(negedge clk);
        rx_en[0] = 1'b0;
        cfg_addr_i = AW'(O_XFERCNT); cfg_valid_i = 1'b1; cfg_rw_ni = 1'b0; cfg_data_i = 32'h0;
        @(negedge clk);
        cfg_valid_i = 1'b0; cfg_rw_ni = 1'b1;
        @(negedge clk);
        rd(0, O_XFERCNT, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL same_cycle_xfercnt got=%h exp=1", v); end
    endtask

    task automatic test_saturation();
        logic [31:0] v;
        wr(0, O_XFERCNT, 32'h0);
        for (int i = 0; i < 300; i++) done_pulse(0);
        rd(0, O_XFERCNT, v);
        checks++; if (v !== 32'hFF) begin errors++; $display("FAIL sat_xfercnt got=%h exp=ff", v); end
        wr(0, O_XFERCNT, 32'h1234);
        rd(0, O_XFERCNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sat_clear got=%h exp=0", v); end
    endtask

    task automatic test_fsm();
        logic [31:0] v, rp; logic p0, p1, p2; logic [NUM_CH-1:0] em, ep, cm;
        wr(0, O_XFERCNT, 32'h0);
        wr(0, O_CFG, 32'h11);
        rd(0, O_STATUS, v);
        checks++; if (v[3:2] !== 2'd1) begin errors++; $display("FAIL fsm_run got=%0d exp=1", v[3:2]); end
        @(negedge clk) begin rx_pend[0] = 1'b1; rx_en[0] = 1'b1; end
        rd(0, O_CFG, v);
        checks++; if (v !== 32'h31) begin errors++; $display("FAIL cfg_status_bits got=%h exp=31", v); end
        @(negedge clk) rx_en[0] = 1'b0;
        @(negedge clk) rx_pend[0] = 1'b0;
        rd(0, O_XFERCNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL pending_no_done got=%h exp=0", v); end
        done_pulse(0);
        rd(0, O_STATUS, v);
        checks++; if (v[3:2] !== 2'd1) begin errors++; $display("FAIL fsm_continuous got=%0d exp=1", v[3:2]); end
        wr(0, O_CFG, 32'h00);
        done_pulse(0);
        rd(0, O_STATUS, v);
        checks++; if (v[3:2] !== 2'd0) begin errors++; $display("FAIL fsm_done_idle got=%0d exp=0", v[3:2]); end
        wr(0, O_CFG, 32'h11);
        bus_xfer(0, O_CFG, 1'b0, 32'h20, v, rp, p0, p1, p2, em, ep, cm);
        checks++; if (cm !== 2'b01 || em !== 2'b00) begin errors++;
            $display("FAIL clr_pulse clr=%b en=%b exp 01/00", cm, em); end
        rd(0, O_STATUS, v);
        checks++; if (v[3:2] !== 2'd0) begin errors++; $display("FAIL fsm_clr_idle got=%0d exp=0", v[3:2]); end
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        wr(0, 5'h18, 32'hFFFF_FFFF);
        rd(0, 5'h18, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", v); end
        checks++; if (startaddr[11:0] !== 12'hABC) begin errors++; $display("FAIL unmapped_side_effect got=%h exp=abc", startaddr[11:0]); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] r; logic rdy; logic [2:0] em, cm;
        bus3(7'h48, 1'b0, 32'h1, r, rdy, em, cm);
        checks++; if (d2_cont !== 3'b100) begin errors++; $display("FAIL ch2_write got=%b exp=100", d2_cont); end
        bus3(7'h68, 1'b1, 32'h0, r, rdy, em, cm);
        checks++; if (rdy !== 1'b1 || r !== 32'h0) begin errors++;
            $display("FAIL oor_read ready=%b data=%h exp 1/0", rdy, r); end
        bus3(7'h68, 1'b0, 32'h3F, r, rdy, em, cm);
        checks++; if (rdy !== 1'b1 || em !== 3'b000 || cm !== 3'b000) begin errors++;
            $display("FAIL oor_write ready=%b en=%b clr=%b exp 1/000/000", rdy, em, cm); end
        checks++; if (d2_cont !== 3'b100 || d2_filter !== 3'b000 || d2_datasize !== 6'h0) begin errors++;
            $display("FAIL oor_no_change cont=%b filter=%b dsize=%h", d2_cont, d2_filter, d2_datasize); end
        bus3(7'h48, 1'b1, 32'h0, r, rdy, em, cm);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL ch2_readback got=%h exp=1", r); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        cfg_valid_i = 1'b0; cfg_rw_ni = 1'b1; cfg_data_i = '0; cfg_addr_i = '0;
        rx_en = '0; rx_pend = '0; curr_addr = '0; bytes_left = '0;
        d2_valid = 1'b0; d2_rw_n = 1'b1; d2_wdata = '0; d2_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_cfg_write();
        test_data_regs();
        test_done_irq();
        test_overflow();
        test_same_cycle();
        test_saturation();
        test_fsm();
        test_unmapped();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
